// File: rtl/decomp_sched_if.sv
// Bus bundle between decomp_sched and its neighbours: coefficient RAM read port,
// coeff_decomposer input/output handshakes and the result write port.
interface decomp_sched_if #(
    parameter int ADDR_W  = 11,
    parameter int COEFF_W = 24
);
    logic               rd_en;
    logic [ADDR_W-1:0]  rd_addr;
    logic [COEFF_W-1:0] rd_data;

    logic               dec_valid_i;
    logic [COEFF_W-1:0] dec_di;
    logic               dec_ready_i;
    logic               dec_valid_o;
    logic [COEFF_W-1:0] dec_doa;
    logic [COEFF_W-1:0] dec_dob;
    logic               dec_ready_o;

    logic               wr_en;
    logic [ADDR_W-1:0]  wr_addr;
    logic [COEFF_W-1:0] wr_doa;
    logic [COEFF_W-1:0] wr_dob;

    modport master (
        output rd_en, rd_addr, dec_valid_i, dec_di, dec_ready_o,
               wr_en, wr_addr, wr_doa, wr_dob,
        input  rd_data, dec_ready_i, dec_valid_o, dec_doa, dec_dob
    );

    modport slave (
        input  rd_en, rd_addr, dec_valid_i, dec_di, dec_ready_o,
               wr_en, wr_addr, wr_doa, wr_dob,
        output rd_data, dec_ready_i, dec_valid_o, dec_doa, dec_dob
    );
endinterface

// File: rtl/decomp_sched.sv
// Streams all k*256 coefficients from RAM through coeff_decomposer and writes the
// (r1, r0) results back in address order; k comes from sec_lvl latched at start.
module decomp_sched #(
    parameter int ADDR_W  = 11,
    parameter int COEFF_W = 24
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [2:0]     sec_lvl,
    output logic           busy,
    output logic           done,
    output logic           err,
    decomp_sched_if.master bus
);
    localparam int CNT_W = ADDR_W + 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Coefficient count for a security level; zero marks an illegal level.
    function automatic logic [CNT_W-1:0] level_total(input logic [2:0] lvl);
        logic [CNT_W-1:0] t;
        case (lvl)
            3'd2:    t = CNT_W'(32'd1024);
            3'd3:    t = CNT_W'(32'd1536);
            3'd5:    t = CNT_W'(32'd2048);
            default: t = {CNT_W{1'b0}};
        endcase
        return t;
    endfunction

    state_t             state_r;
    logic [CNT_W-1:0]   total_r;
    logic [CNT_W-1:0]   rc_r;
    logic [CNT_W-1:0]   wc_r;
    logic               busy_r;
    logic               done_r;
    logic               err_r;
    logic               infl_r;
    logic               head_r;
    logic               tail_r;
    logic [1:0]         occ_r;
    logic [COEFF_W-1:0] fifo_mem_r [2];

    logic [CNT_W-1:0]   lvl_total_s;
    logic               start_ok_s;
    logic [2:0]         credit_s;
    logic               rd_en_s;
    logic               pop_s;
    logic               push_s;
    logic               wr_en_s;
    logic               last_rd_s;
    logic               last_wr_s;

    assign lvl_total_s = level_total(sec_lvl);
    assign start_ok_s  = (state_r == ST_IDLE) && start && (lvl_total_s != {CNT_W{1'b0}});
    assign pop_s       = (occ_r != 2'd0) && bus.dec_ready_i;
    assign push_s      = infl_r;
    assign wr_en_s     = bus.dec_valid_o && busy_r;
    assign last_rd_s   = rd_en_s && (rc_r == (total_r - CNT_W'(32'd1)));
    assign last_wr_s   = wr_en_s && (wc_r == (total_r - CNT_W'(32'd1)));

    // Read credit: FIFO entries plus the read in flight, less this cycle's pop, stay below two.
    always_comb begin
        credit_s = {1'b0, occ_r} + {2'b00, infl_r};
        if ((state_r == ST_RUN) && (credit_s < (3'd2 + {2'b00, pop_s}))) begin
            rd_en_s = 1'b1;
        end else begin
            rd_en_s = 1'b0;
        end
    end

    // Sequencer FSM with its counters and registered status pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
            total_r <= {CNT_W{1'b0}};
            rc_r    <= {CNT_W{1'b0}};
            wc_r    <= {CNT_W{1'b0}};
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            err_r   <= 1'b0;
        end else begin
            done_r <= 1'b0;
            err_r  <= 1'b0;
            if (rd_en_s) begin
                rc_r <= rc_r + CNT_W'(32'd1);
            end
            if (wr_en_s) begin
                wc_r <= wc_r + CNT_W'(32'd1);
            end
            case (state_r)
                ST_IDLE: begin
                    if (start_ok_s) begin
                        total_r <= lvl_total_s;
                        rc_r    <= {CNT_W{1'b0}};
                        wc_r    <= {CNT_W{1'b0}};
                        busy_r  <= 1'b1;
                        state_r <= ST_RUN;
                    end else if (start) begin
                        err_r <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (last_rd_s) begin
                        state_r <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (last_wr_s) begin
                        done_r  <= 1'b1;
                        state_r <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
                default: begin
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    // Two-entry input FIFO; RAM data lands one cycle after its read strobe.
    always_ff @(posedge clk) begin
        if (rst) begin
            infl_r <= 1'b0;
            head_r <= 1'b0;
            tail_r <= 1'b0;
            occ_r  <= 2'd0;
            for (int i = 0; i < 2; i++) begin
                fifo_mem_r[i] <= {COEFF_W{1'b0}};
            end
        end else begin
            infl_r <= rd_en_s;
            if (start_ok_s) begin
                head_r <= 1'b0;
                tail_r <= 1'b0;
                occ_r  <= 2'd0;
            end else begin
                if (push_s) begin
                    fifo_mem_r[tail_r] <= bus.rd_data;
                    tail_r             <= ~tail_r;
                end
                if (pop_s) begin
                    head_r <= ~head_r;
                end
                case ({push_s, pop_s})
                    2'b10:   occ_r <= occ_r + 2'd1;
                    2'b01:   occ_r <= occ_r - 2'd1;
                    default: occ_r <= occ_r;
                endcase
            end
        end
    end

    assign busy            = busy_r;
    assign done            = done_r;
    assign err             = err_r;

    assign bus.rd_en       = rd_en_s;
    assign bus.rd_addr     = rc_r[ADDR_W-1:0];
    assign bus.dec_valid_i = (occ_r != 2'd0);
    assign bus.dec_di      = fifo_mem_r[head_r];
    assign bus.dec_ready_o = busy_r;

    // Write data is gated so the write port reads zero whenever no result is accepted.
    assign bus.wr_en       = wr_en_s;
    assign bus.wr_addr     = wc_r[ADDR_W-1:0];
    assign bus.wr_doa      = wr_en_s ? bus.dec_doa : {COEFF_W{1'b0}};
    assign bus.wr_dob      = wr_en_s ? bus.dec_dob : {COEFF_W{1'b0}};
endmodule

// File: tb/tb_decomp_sched.sv
// Directed bench for decomp_sched with a RAM model and a one-stage decomposer model.
module tb_decomp_sched;
    localparam int ADDR_W  = 11;
    localparam int COEFF_W = 24;
    localparam int Q       = 8380417;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [2:0] sec_lvl;
    logic       busy;
    logic       done;
    logic       err;

    decomp_sched_if #(.ADDR_W(ADDR_W), .COEFF_W(COEFF_W)) bus ();

    decomp_sched #(.ADDR_W(ADDR_W), .COEFF_W(COEFF_W)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .sec_lvl (sec_lvl),
        .busy    (busy),
        .done    (done),
        .err     (err),
        .bus     (bus.master)
    );

    always #5 clk = ~clk;

    int          ram [2048];
    int          n_chk = 0;
    int          n_bad = 0;
    int          cur_g2 = 190464;
    int          wr_cnt = 0;
    int          rd_cnt = 0;
    int          done_cnt = 0;
    int          err_cnt = 0;
    int          out_cnt = 0;
    int          max_out = 0;
    logic [23:0] wa_log [2048];
    logic [23:0] wb_log [2048];
    logic        prev_stall = 1'b0;
    logic [23:0] prev_di = 24'd0;

    logic        mdl_vld = 1'b0;
    logic [23:0] mdl_a = 24'd0;
    logic [23:0] mdl_b = 24'd0;

    // Reference Decompose: r1 in the upper half, r0 (two's complement) in the lower half.
    function automatic logic [47:0] ref_dec(input int a, input int g2);
        int r0;
        int r1;
        r0 = a % g2;
        if (r0 > g2 / 2) r0 = r0 - g2;
        if (a - r0 == Q - 1) begin
            r1 = 0;
            r0 = r0 - 1;
        end else begin
            r1 = (a - r0) / g2;
        end
        return {r1[23:0], r0[23:0]};
    endfunction

    task automatic check_eq(input string tag, input logic [47:0] act, input logic [47:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h want=%0h", tag, act, exp);
        end
    endtask

    assign bus.dec_valid_o = mdl_vld;
    assign bus.dec_doa     = mdl_a;
    assign bus.dec_dob     = mdl_b;

    always @(posedge clk) begin
        if (bus.rd_en) bus.rd_data <= ram[bus.rd_addr];
    end

    always @(posedge clk) begin
        if (rst) begin
            mdl_vld <= 1'b0;
        end else if (bus.dec_valid_i && bus.dec_ready_i) begin
            mdl_vld        <= 1'b1;
            {mdl_a, mdl_b} <= ref_dec(int'(bus.dec_di), cur_g2);
        end else if (bus.dec_ready_o) begin
            mdl_vld <= 1'b0;
        end
    end

    // Monitor: counts strobes, checks write order/data, outstanding reads and input hold.
    initial begin
        forever begin
            @(negedge clk);
            if (bus.rd_en) rd_cnt++;
            out_cnt = out_cnt + int'(bus.rd_en) - int'(bus.dec_valid_i && bus.dec_ready_i);
            if (out_cnt > max_out) max_out = out_cnt;
            if (bus.wr_en) begin
                check_eq("wr_addr", 48'(bus.wr_addr), 48'(wr_cnt[10:0]));
                check_eq("wr_data", {bus.wr_doa, bus.wr_dob}, ref_dec(ram[bus.wr_addr], cur_g2));
                wa_log[bus.wr_addr] = bus.wr_doa;
                wb_log[bus.wr_addr] = bus.wr_dob;
                wr_cnt++;
            end
            if (done) done_cnt++;
            if (err) err_cnt++;
            if (prev_stall) check_eq("di_hold", {23'd0, bus.dec_valid_i, bus.dec_di}, {23'd0, 1'b1, prev_di});
            prev_stall = bus.dec_valid_i && !bus.dec_ready_i && !rst;
            prev_di    = bus.dec_di;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic init_ram(input int v0, input int vlast, input int last);
        for (int i = 0; i < 2048; i++) ram[i] = (i * 8183) % Q;
        ram[0]    = v0;
        ram[last] = vlast;
    endtask

    task automatic start_run(input logic [2:0] lvl, input int g2);
        tick();
        wr_cnt = 0; rd_cnt = 0; done_cnt = 0; err_cnt = 0; out_cnt = 0; max_out = 0;
        cur_g2 = g2;
        bus.dec_ready_i = 1'b1;
        sec_lvl = lvl;
        start = 1'b1;
        tick();
        start = 1'b0;
        sec_lvl = 3'd7;
    endtask

    task automatic run_wait(input bit bp, input bit chk_start, input int first_di,
                            input int poke_at, input int stop_wr, input int budget,
                            output int done_k);
        done_k = 0;
        for (int k = 1; k <= budget; k++) begin
            @(negedge clk);
            if (chk_start && k == 1) begin
                check_eq("s1_busy", 48'(busy), 48'd1);
                check_eq("s1_rd_en", 48'(bus.rd_en), 48'd1);
                check_eq("s1_rd_addr", 48'(bus.rd_addr), 48'd0);
                check_eq("s1_valid", 48'(bus.dec_valid_i), 48'd0);
            end
            if (chk_start && k == 2) begin
                check_eq("s2_valid", 48'(bus.dec_valid_i), 48'd0);
                check_eq("s2_rd_addr", 48'(bus.rd_addr), 48'd1);
            end
            if (chk_start && k == 3) begin
                check_eq("s3_valid", 48'(bus.dec_valid_i), 48'd1);
                check_eq("s3_di", 48'(bus.dec_di), 48'(first_di));
            end
            if (done) begin
                done_k = k;
                break;
            end
            if (stop_wr > 0 && wr_cnt >= stop_wr) begin
                done_k = -k;
                break;
            end
            @(posedge clk);
            #1;
            if (k == poke_at) begin
                start   = 1'b1;
                sec_lvl = 3'd1;
            end else begin
                start = 1'b0;
            end
            bus.dec_ready_i = bp ? ($urandom_range(0, 1) == 1) : 1'b1;
        end
    endtask

    task automatic check_reset_vals();
        check_eq("rv_busy", 48'(busy), 48'd0);
        check_eq("rv_done", 48'(done), 48'd0);
        check_eq("rv_err", 48'(err), 48'd0);
        check_eq("rv_rd_en", 48'(bus.rd_en), 48'd0);
        check_eq("rv_valid_i", 48'(bus.dec_valid_i), 48'd0);
        check_eq("rv_ready_o", 48'(bus.dec_ready_o), 48'd0);
        check_eq("rv_wr_en", 48'(bus.wr_en), 48'd0);
        check_eq("rv_rd_addr", 48'(bus.rd_addr), 48'd0);
        check_eq("rv_wr_addr", 48'(bus.wr_addr), 48'd0);
        check_eq("rv_di", 48'(bus.dec_di), 48'd0);
        check_eq("rv_doa", 48'(bus.wr_doa), 48'd0);
        check_eq("rv_dob", 48'(bus.wr_dob), 48'd0);
    endtask

    initial begin
        int dk;
        int wb;
        rst = 1'b1;
        start = 1'b0;
        sec_lvl = 3'd0;
        bus.dec_ready_i = 1'b1;
        init_ram(0, 0, 0);
        repeat (3) tick();
        @(negedge clk);
        check_reset_vals();
        tick();
        rst = 1'b0;

        // Level 2, always ready, Q-1 at address 0 and 190463 at address 1023.
        init_ram(8380416, 190463, 1023);
        start_run(3'd2, 190464);
        run_wait(1'b0, 1'b1, 8380416, 0, 0, 5000, dk);
        check_eq("a_done_cyc", 48'(dk), 48'd1028);
        check_eq("a_writes", 48'(wr_cnt), 48'd1024);
        check_eq("a_reads", 48'(rd_cnt), 48'd1024);
        check_eq("a_max_out", 48'(max_out), 48'd2);
        check_eq("a_first", {wa_log[0], wb_log[0]}, {24'h000000, 24'hFFFFFF});
        check_eq("a_last", {wa_log[1023], wb_log[1023]}, {24'h000001, 24'hFFFFFF});

        // Level 5 back-to-back, 50% input backpressure.
        init_ram(190464, 190463, 2047);
        start_run(3'd5, 523776);
        run_wait(1'b1, 1'b0, 0, 0, 0, 20000, dk);
        check_eq("b_done_seen", 48'(dk > 0), 48'd1);
        check_eq("b_writes", 48'(wr_cnt), 48'd2048);
        check_eq("b_reads", 48'(rd_cnt), 48'd2048);
        check_eq("b_max_out", 48'(max_out), 48'd2);
        check_eq("b_first", {wa_log[0], wb_log[0]}, {24'h000000, 24'h02E800});
        check_eq("b_last", {wa_log[2047], wb_log[2047]}, {24'h000000, 24'h02E7FF});
        bus.dec_ready_i = 1'b1;

        // Illegal level.
        tick();
        rd_cnt = 0; err_cnt = 0; done_cnt = 0;
        sec_lvl = 3'd1;
        start = 1'b1;
        tick();
        start = 1'b0;
        @(negedge clk);
        check_eq("il_err", 48'(err), 48'd1);
        check_eq("il_busy", 48'(busy), 48'd0);
        check_eq("il_rd_en", 48'(bus.rd_en), 48'd0);
        repeat (3) @(negedge clk);
        check_eq("il_err_pulse", 48'(err_cnt), 48'd1);
        check_eq("il_no_reads", 48'(rd_cnt), 48'd0);
        check_eq("il_no_done", 48'(done_cnt), 48'd0);
        check_eq("il_busy_after", 48'(busy), 48'd0);

        // Level 3 with a second (illegal-level) start at cycle 500.
        init_ram(0, 0, 0);
        start_run(3'd3, 523776);
        run_wait(1'b0, 1'b0, 0, 500, 0, 5000, dk);
        check_eq("c_done_seen", 48'(dk > 0), 48'd1);
        check_eq("c_writes", 48'(wr_cnt), 48'd1536);
        repeat (5) @(negedge clk);
        check_eq("c_done_cnt", 48'(done_cnt), 48'd1);
        check_eq("c_err_cnt", 48'(err_cnt), 48'd0);
        check_eq("c_busy_after", 48'(busy), 48'd0);

        // Level 3 reset at write 700, then a fresh level-2 run.
        start_run(3'd3, 523776);
        run_wait(1'b0, 1'b0, 0, 0, 700, 5000, dk);
        check_eq("d_reached_700", 48'(dk < 0), 48'd1);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        check_reset_vals();
        wb = wr_cnt;
        repeat (5) @(negedge clk);
        check_eq("d_no_stale", 48'(wr_cnt), 48'(wb));
        check_eq("d_idle_busy", 48'(busy), 48'd0);
        init_ram(0, 190464, 1023);
        start_run(3'd2, 190464);
        run_wait(1'b0, 1'b1, 0, 0, 0, 5000, dk);
        check_eq("e_done_cyc", 48'(dk), 48'd1028);
        check_eq("e_writes", 48'(wr_cnt), 48'd1024);
        check_eq("e_first", {wa_log[0], wb_log[0]}, {24'h000000, 24'h000000});
        check_eq("e_last", {wa_log[1023], wb_log[1023]}, {24'h000001, 24'h000000});

        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule

// File: doc/decomp_sched.md
# decomp_sched

Sequencer that streams every coefficient of a k×256 polynomial vector from coefficient RAM through `coeff_decomposer` and writes both results back in order. It sits between the polynomial RAM and the decomposer in the signing datapath (HighBits/LowBits of w). It owns the RAM read port, the decomposer's input/output handshakes and the result write port. The vector length comes from the security level latched at `start`.

## Interface
- `ADDR_W`, 11: coefficient address width; covers 8×256 = 2048 coefficients.
- `COEFF_W`, 24: coefficient/result width.
- `clk`  in  1  single clock, all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  one-cycle request; accepted only in IDLE.
- `sec_lvl`  in  3  3'd2 / 3'd3 / 3'd5 gives k = 4 / 6 / 8; sampled at accepted `start`.
- `busy`  out  1  high from the cycle after an accepted `start` through the DONE state.
- `done`  out  1  one-cycle pulse after the final write.
- `err`  out  1  one-cycle pulse when `start` arrives in IDLE with an illegal `sec_lvl`.
- `rd_en`  out  1  RAM read strobe.
- `rd_addr`  out  ADDR_W  RAM read address.
- `rd_data`  in  COEFF_W  RAM data, valid exactly 1 cycle after `rd_en`.
- `dec_valid_i`  out  1  drives the decomposer `valid_i`.
- `dec_di`  out  COEFF_W  drives the decomposer `di`.
- `dec_ready_i`  in  1  decomposer input ready (its `ready_i`).
- `dec_valid_o`  in  1  decomposer result valid.
- `dec_doa`  in  COEFF_W  decomposer `doa` (high part r1).
- `dec_dob`  in  COEFF_W  decomposer `dob` (low part r0).
- `dec_ready_o`  out  1  drives the decomposer `ready_o`; equals `busy`.
- `wr_en`  out  1  result write strobe.
- `wr_addr`  out  ADDR_W  result address.
- `wr_doa`  out  COEFF_W  r1 write data.
- `wr_dob`  out  COEFF_W  r0 write data.

## Operation
- **States:** IDLE, RUN, DRAIN, DONE.
- **IDLE to RUN:** on `start` with a legal `sec_lvl`.
  - Latch `total` = k·256, i.e. 1024 / 1536 / 2048.
  - Clear the read counter `rc`, the write counter `wc` and the FIFO.
- **IDLE with illegal `sec_lvl`:** pulse `err`, stay in IDLE and issue no reads.
- **RUN:** `rd_en`=1 and `rd_addr`=`rc` whenever `occ + infl − pop < 2`.
  - `occ` is the FIFO occupancy (0..2).
  - `infl` is 1 if `rd_en` was high last cycle.
  - `pop` = `dec_valid_i & dec_ready_i`.
  - `rc` increments on each read.
- **RUN to DRAIN:** the cycle after the read with `rc` = `total`−1.
- **Input FIFO:** 2 entries; pushed with `rd_data` one cycle after `rd_en`.
  - `dec_valid_i` = FIFO non-empty; `dec_di` = FIFO head.
  - `dec_valid_i`/`dec_di` are held stable until popped.
  - The FIFO can never overflow, by the credit rule above.
- **Writeback:** on `dec_valid_o & dec_ready_o`, drive `wr_en`=1, `wr_addr`=`wc`, `wr_doa`=`dec_doa`, `wr_dob`=`dec_dob`, then increment `wc`.
  - Results are in order, so the write address equals the read address of the same coefficient.
- **DRAIN to DONE:** the cycle after the write with `wc` = `total`−1.
- **DONE:** pulse `done` for 1 cycle, then return to IDLE.
- **Ignored inputs:**
  - `start` outside IDLE is ignored: no restart and no `err`.
  - `sec_lvl` changes after latching are ignored.
- **Reset:** `rst` at any time, including mid-run, returns to IDLE.
  - Clears the counters and the FIFO.
  - In-flight decomposer results are discarded: `dec_ready_o`=0 and no `wr_en`.
- **Counters:** `rc` and `wc` are ADDR_W+1 bits wide, so `total` = 2048 is representable; `rd_addr`/`wr_addr` are the low ADDR_W bits.

## Timing
- **Reset values:** `busy`, `done`, `err`, `rd_en`, `dec_valid_i`, `dec_ready_o` and `wr_en` are all 0; `rd_addr`, `wr_addr`, `dec_di`, `wr_doa` and `wr_dob` are all 0.
- **Startup, with `start` in cycle t:**
  - t+1: RUN, `busy`=1, first `rd_en`.
  - t+2: `rd_data` pushed.
  - t+3: first `dec_valid_i`=1.
- **Throughput:** sustained 1 coefficient per cycle while `dec_ready_i`=1. When `dec_ready_i` is held low, at most 2 outstanding (FIFO plus in-flight) before `rd_en` stops.
- **Write latency:** `wr_en` is combinational from `dec_valid_o` (zero cycles).
- **Final write:** `done` is high the cycle after the final write, and `busy` falls with it.
- **Back-to-back runs:** a new `start` is accepted in the cycle after `done`.
- **`err`:** asserted in the cycle after the offending `start`.

## Test plan
- **Level 2 run:** `sec_lvl`=2, RAM[i]=i·8183 mod Q, decomposer always ready.
  - Expect exactly 1024 `rd_en` and 1024 `wr_en`, with `wr_addr` = 0..1023 in order.
  - The results match the reference decompose (2γ2 = 190464).
  - `done` at the cycle after the last write; total run ≈ 1027 cycles.
- **Level 5 with backpressure:** `sec_lvl`=5, random `dec_ready_i` at 50% duty.
  - Expect 2048 writes in order and `dec_di` stable while stalled.
  - FIFO occupancy never exceeds 2; 2γ2 = 523776 (the γ2 used by levels 3 and 5).
- **Boundary values:** coefficients 0, Q−1 = 8380416, 190463 and 190464 at the first and last addresses.
  - Expect the correct r1/r0 at addresses 0 and `total`−1.
- **Illegal level:** `sec_lvl`=3'd1 with `start`.
  - Expect an `err` pulse 1 cycle later, with no `rd_en`, no `busy` and no `done`.
- **Repeated start:** a second `start` at cycle 500 of a level-3 run.
  - Expect it ignored: still exactly 1536 writes and 1 `done`.
- **Mid-run reset:** `rst` at write 700 of a level-3 run, then a fresh level-2 `start`.
  - Expect all outputs at reset values the next cycle, no stale writes, and the level-2 run to complete with 1024 writes starting at address 0.
